// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock first-word-fall-through FIFO with occupancy count,
// runtime-programmable almost-full / almost-empty flags, synchronous flush
// and sticky overflow / underflow error flags.
//
// Ports
//   clock                 in   rising-edge clock
//   rst                   in   asynchronous, active-high reset
//   data_in               in   write data
//   data_in_valid         in   write request
//   data_in_full          out  FIFO holds BUFFER_SIZE words; writes ignored
//   data_in_almost_full   out  fill_level >= almost_full_level
//   data_out              out  head word (valid only while data_out_valid)
//   data_out_valid        out  FIFO non-empty
//   data_out_ack          in   consumer pops the head word
//   data_out_almost_empty out  fill_level <= almost_empty_level
//   fill_level            out  number of stored words, 0..BUFFER_SIZE
//   almost_full_level     in   almost-full threshold (quasi-static)
//   almost_empty_level    in   almost-empty threshold (quasi-static)
//   flush                 in   synchronous discard of all contents
//   overflow              out  sticky: write attempted while full
//   underflow             out  sticky: ack while empty
//   clear_errors          in   clears overflow / underflow
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter  int BUFFER_SIZE   = 16,
    parameter  int DATA_WIDTH    = 32,
    localparam int ADDRESS_WIDTH = (BUFFER_SIZE < 2) ? 1 : $clog2(BUFFER_SIZE),
    localparam int COUNT_WIDTH   = ADDRESS_WIDTH + 1
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_full,
    output logic                   data_in_almost_full,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ack,
    output logic                   data_out_almost_empty,
    output logic [COUNT_WIDTH-1:0] fill_level,
    input  logic [COUNT_WIDTH-1:0] almost_full_level,
    input  logic [COUNT_WIDTH-1:0] almost_empty_level,
    input  logic                   flush,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clear_errors
);

    generate
        if ((BUFFER_SIZE < 2) || ((BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0)) begin : g_bad_size
            $error("sync_fifo_flags: BUFFER_SIZE must be a power of two and at least 2");
        end
    endgenerate

    // Storage is not reset; the zero initialiser only gives a defined
    // data_out in simulation before the first write.
    logic [DATA_WIDTH-1:0]    r_mem [BUFFER_SIZE] = '{default: '0};

    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [COUNT_WIDTH-1:0]   r_fill;
    logic                     r_overflow;
    logic                     r_underflow;

    logic                     w_full;
    logic                     w_valid;
    logic                     w_wr_en;
    logic                     w_rd_en;
    logic                     w_overflow_set;
    logic                     w_underflow_set;

    // Full and empty are decoded only from the occupancy register, so the
    // pointers are free to roll over naturally.
    assign w_full  = (r_fill == COUNT_WIDTH'(BUFFER_SIZE));
    assign w_valid = (r_fill != '0);

    assign w_wr_en = data_in_valid & ~w_full;
    assign w_rd_en = data_out_ack & w_valid;

    assign w_overflow_set  = data_in_valid & w_full;
    assign w_underflow_set = data_out_ack & ~w_valid;

    // Flush wins over any concurrent write, so the word is never stored.
    always_ff @(posedge clock) begin
        if (w_wr_en && !flush) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDRESS_WIDTH'(1);
            end
            if (w_wr_en && !w_rd_en) begin
                r_fill <= r_fill + COUNT_WIDTH'(1);
            end else if (w_rd_en && !w_wr_en) begin
                r_fill <= r_fill - COUNT_WIDTH'(1);
            end
        end
    end

    // Error flags keep updating during flush; a new error in the same cycle
    // as clear_errors still registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_overflow_set  | (r_overflow  & ~clear_errors);
            r_underflow <= w_underflow_set | (r_underflow & ~clear_errors);
        end
    end

    assign data_out              = r_mem[r_rd_ptr];
    assign data_out_valid        = w_valid;
    assign data_in_full          = w_full;
    assign fill_level            = r_fill;
    assign data_in_almost_full   = (r_fill >= almost_full_level);
    assign data_out_almost_empty = (r_fill <= almost_empty_level);
    assign overflow              = r_overflow;
    assign underflow             = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Self-checking bench for sync_fifo_flags (BUFFER_SIZE=16, DATA_WIDTH=32).
// A queue-based reference model tracks contents and sticky error flags.
// Inputs change 1 ns after the rising edge; outputs are compared there too.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flags;

    localparam int BS = 16;
    localparam int DW = 32;
    localparam int CW = 5;

    logic          clock;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_full;
    logic          data_in_almost_full;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ack;
    logic          data_out_almost_empty;
    logic [CW-1:0] fill_level;
    logic [CW-1:0] almost_full_level;
    logic [CW-1:0] almost_empty_level;
    logic          flush;
    logic          overflow;
    logic          underflow;
    logic          clear_errors;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_q [$];
    bit            m_ovf;
    bit            m_udf;

    sync_fifo_flags #(.BUFFER_SIZE(BS), .DATA_WIDTH(DW)) dut (
        .clock                 (clock),
        .rst                   (rst),
        .data_in               (data_in),
        .data_in_valid         (data_in_valid),
        .data_in_full          (data_in_full),
        .data_in_almost_full   (data_in_almost_full),
        .data_out              (data_out),
        .data_out_valid        (data_out_valid),
        .data_out_ack          (data_out_ack),
        .data_out_almost_empty (data_out_almost_empty),
        .fill_level            (fill_level),
        .almost_full_level     (almost_full_level),
        .almost_empty_level    (almost_empty_level),
        .flush                 (flush),
        .overflow              (overflow),
        .underflow             (underflow),
        .clear_errors          (clear_errors)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock of the reference model, using the inputs as currently driven.
    task automatic tick();
        bit full, valid, wr, rd;
        full  = (m_q.size() == BS);
        valid = (m_q.size() != 0);
        wr    = data_in_valid && !full;
        rd    = data_out_ack && valid;
        m_ovf = (data_in_valid && full) || (m_ovf && !clear_errors);
        m_udf = (data_out_ack && !valid) || (m_udf && !clear_errors);
        if (flush) begin
            m_q.delete();
        end else begin
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(data_in);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        data_in       = '0;
        data_in_valid = 1'b0;
        data_out_ack  = 1'b0;
        flush         = 1'b0;
        clear_errors  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        almost_full_level  = 5'd0;
        almost_empty_level = 5'd3;
        m_q.delete(); m_ovf = 0; m_udf = 0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        n_checks++; if (data_in_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", data_in_full); end
        n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", data_out_valid); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_errors got=%0b%0b exp=00", overflow, underflow); end
        n_checks++; if (data_out_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got=%0b exp=1", data_out_almost_empty); end
        n_checks++; if (data_in_almost_full !== 1'b1) begin n_fail++; $display("FAIL reset_af_zero got=%0b exp=1", data_in_almost_full); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_dout got=%0h exp=0", data_out); end
        almost_full_level = 5'd12;
        #1;
        n_checks++; if (data_in_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af_12 got=%0b exp=0", data_in_almost_full); end
        @(negedge clock);
        rst = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i <= BS; i++) begin
            data_in       = DW'(i);
            data_in_valid = 1'b1;
            tick();
            n_checks++; if (fill_level !== CW'(m_q.size())) begin n_fail++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, fill_level, m_q.size()); end
            n_checks++; if (data_in_full !== (m_q.size() == BS)) begin n_fail++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, data_in_full, m_q.size() == BS); end
        end
        data_in_valid = 1'b0;
        n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL fill_final got=%0d exp=16", fill_level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got=%0b exp=1", overflow); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL fill_underflow got=%0b exp=0", underflow); end
    endtask

    task automatic test_drain();
        data_out_ack = 1'b1;
        for (int i = 0; i < BS; i++) begin
            n_checks++; if (data_out_valid !== 1'b1 || data_out !== DW'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got=%0h/v%0b exp=%0h", i, data_out, data_out_valid, i); end
            tick();
        end
        n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0b exp=0", data_out_valid); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_no_udf got=%0b exp=0", underflow); end
        tick();
        data_out_ack = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL drain_udf got=%0b exp=1", underflow); end
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL drain_fill got=%0d exp=0", fill_level); end
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL drain_clear got=%0b%0b exp=00", overflow, underflow); end
    endtask

    task automatic test_streaming();
        data_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = $urandom;
            tick();
        end
        data_out_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data_in = $urandom;
            n_checks++; if (data_out !== m_q[0]) begin n_fail++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, data_out, m_q[0]); end
            tick();
            n_checks++; if (fill_level !== 5'd8) begin n_fail++; $display("FAIL stream_fill[%0d] got=%0d exp=8", i, fill_level); end
        end
        data_in_valid = 1'b0;
        while (m_q.size() != 0) begin
            n_checks++; if (data_out !== m_q[0]) begin n_fail++; $display("FAIL stream_tail got=%0h exp=%0h", data_out, m_q[0]); end
            tick();
        end
        data_out_ack = 1'b0;
    endtask

    task automatic test_almost_flags();
        almost_full_level  = 5'd12;
        almost_empty_level = 5'd3;
        data_in_valid = 1'b1;
        for (int i = 0; i < BS; i++) begin
            data_in = $urandom;
            tick();
            n_checks++; if (data_in_almost_full !== (m_q.size() >= 12)) begin n_fail++; $display("FAIL af_up[%0d] got=%0b exp=%0b", m_q.size(), data_in_almost_full, m_q.size() >= 12); end
            n_checks++; if (data_out_almost_empty !== (m_q.size() <= 3)) begin n_fail++; $display("FAIL ae_up[%0d] got=%0b exp=%0b", m_q.size(), data_out_almost_empty, m_q.size() <= 3); end
        end
        data_in_valid = 1'b0;
        data_out_ack  = 1'b1;
        for (int i = 0; i < BS; i++) begin
            n_checks++; if (data_out !== m_q[0]) begin n_fail++; $display("FAIL af_drain_data got=%0h exp=%0h", data_out, m_q[0]); end
            tick();
            n_checks++; if (data_in_almost_full !== (m_q.size() >= 12)) begin n_fail++; $display("FAIL af_down[%0d] got=%0b exp=%0b", m_q.size(), data_in_almost_full, m_q.size() >= 12); end
            n_checks++; if (data_out_almost_empty !== (m_q.size() <= 3)) begin n_fail++; $display("FAIL ae_down[%0d] got=%0b exp=%0b", m_q.size(), data_out_almost_empty, m_q.size() <= 3); end
        end
        data_out_ack = 1'b0;
        almost_full_level = 5'd0;
        #1;
        n_checks++; if (data_in_almost_full !== 1'b1) begin n_fail++; $display("FAIL af_zero_empty got=%0b exp=1", data_in_almost_full); end
        almost_full_level = 5'd12;
        #1;
    endtask

    task automatic test_flush();
        data_out_ack = 1'b1;
        tick();
        data_out_ack = 1'b0;
        data_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = DW'(32'h100 + i);
            tick();
        end
        n_checks++; if (fill_level !== 5'd5) begin n_fail++; $display("FAIL flush_prefill got=%0d exp=5", fill_level); end
        data_in = 32'hDEAD_BEEF;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        data_in_valid = 1'b0;
        n_checks++; if (fill_level !== 5'd0 || data_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got=%0d/v%0b exp=0/v0", fill_level, data_out_valid); end
        n_checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL flush_errors got=%0b%0b exp=01", overflow, underflow); end
        data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = DW'(32'h200 + i);
            tick();
        end
        data_in_valid = 1'b0;
        data_out_ack  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (data_out !== DW'(32'h200 + i)) begin n_fail++; $display("FAIL flush_after[%0d] got=%0h exp=%0h", i, data_out, 32'h200 + i); end
            tick();
        end
        data_out_ack = 1'b0;
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
    endtask

    task automatic test_async_reset();
        data_in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = $urandom;
            tick();
        end
        data_in_valid = 1'b0;
        data_in_valid = 1'b1;
        data_in = 32'hFFFF_FFFF;
        tick();
        data_in_valid = 1'b0;
        n_checks++; if (fill_level !== 5'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL arst_prefill got=%0d exp=8", fill_level); end
        data_out_ack = 1'b1;
        tick();
        data_out_ack = 1'b0;
        // Hold a mid-run state with fill 7, then reset between edges.
        #2;
        rst = 1'b1;
        m_q.delete(); m_ovf = 0; m_udf = 0;
        #1;
        n_checks++; if (fill_level !== 5'd0 || data_out_valid !== 1'b0 || data_in_full !== 1'b0) begin n_fail++; $display("FAIL arst_immediate got=%0d/v%0b exp=0/v0", fill_level, data_out_valid); end
        n_checks++; if (data_out_almost_empty !== 1'b1 || data_in_almost_full !== 1'b0) begin n_fail++; $display("FAIL arst_flags got=ae%0b/af%0b exp=ae1/af0", data_out_almost_empty, data_in_almost_full); end
        @(negedge clock);
        rst = 1'b0;
        @(posedge clock);
        #1;
        data_in       = 32'h0000_00A5;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        n_checks++; if (data_out !== 32'hA5 || data_out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_first_write got=%0h/v%0b exp=a5/v1", data_out, data_out_valid); end
        data_out_ack = 1'b1;
        tick();
        data_out_ack = 1'b0;
    endtask

    task automatic test_random();
        almost_full_level  = 5'd10;
        almost_empty_level = 5'd5;
        for (int i = 0; i < 600; i++) begin
            data_in       = $urandom;
            data_in_valid = ($urandom_range(0, 99) < 60);
            data_out_ack  = ($urandom_range(0, 99) < 50);
            flush         = ($urandom_range(0, 99) < 3);
            clear_errors  = ($urandom_range(0, 99) < 5);
            tick();
            n_checks++; if (fill_level !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_fill[%0d] got=%0d exp=%0d", i, fill_level, m_q.size()); end
            n_checks++; if (data_out_valid !== (m_q.size() != 0) || data_in_full !== (m_q.size() == BS)) begin n_fail++; $display("FAIL rnd_status[%0d] got=v%0b/f%0b exp=v%0b/f%0b", i, data_out_valid, data_in_full, m_q.size() != 0, m_q.size() == BS); end
            if (m_q.size() != 0) begin
                n_checks++; if (data_out !== m_q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got=%0h exp=%0h", i, data_out, m_q[0]); end
            end
            n_checks++; if (overflow !== m_ovf || underflow !== m_udf) begin n_fail++; $display("FAIL rnd_errors[%0d] got=%0b%0b exp=%0b%0b", i, overflow, underflow, m_ovf, m_udf); end
            n_checks++; if (data_in_almost_full !== (m_q.size() >= 10) || data_out_almost_empty !== (m_q.size() <= 5)) begin n_fail++; $display("FAIL rnd_almost[%0d] got=af%0b/ae%0b exp=af%0b/ae%0b", i, data_in_almost_full, data_out_almost_empty, m_q.size() >= 10, m_q.size() <= 5); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain();
        test_streaming();
        test_almost_flags();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
